// File: rtl/decode_issue.sv
// decode_issue: fetch PC generation, field decode, 64x32 register file with
// writeback bypass, and the issue registers that feed the single-cycle ALU.
module decode_issue #(
    parameter logic [13:0] RESET_PC   = 14'd0,
    parameter logic [5:0]  BUBBLE_OPE = 6'b000010
) (
    input  logic        clk,
    input  logic        rstn,
    output logic [13:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        b_is_hazard,
    input  logic [13:0] b_addr,
    input  logic [5:0]  reg_addr,
    input  logic [31:0] reg_dd_val,
    output logic [5:0]  ope,
    output logic [13:0] pc,
    output logic [31:0] ds_val,
    output logic [31:0] dt_val,
    output logic [5:0]  dd,
    output logic [15:0] imm,
    output logic [4:0]  opr,
    output logic        issue_valid
);
    localparam logic [5:0] OPE_J   = 6'b000010;
    localparam logic [5:0] OPE_JAL = 6'b000110;

    logic [13:0] f_pc;
    logic [13:0] d_pc;
    logic        d_valid;
    logic [31:0] rf [0:63];

    logic [5:0]  d_ope;
    logic [5:0]  d_dd;
    logic [5:0]  d_ds;
    logic [5:0]  d_dt;
    logic [15:0] d_imm;
    logic [4:0]  d_opr;
    logic [13:0] d_target;
    logic [31:0] ds_fwd;
    logic [31:0] dt_fwd;
    logic        decode_jump;
    logic        do_issue;

    assign imem_addr = f_pc;

    assign d_ope    = imem_data[31:26];
    assign d_dd     = imem_data[25:20];
    assign d_ds     = imem_data[19:14];
    assign d_dt     = imem_data[13:8];
    assign d_imm    = imem_data[15:0];
    assign d_opr    = imem_data[4:0];
    assign d_target = imem_data[13:0];

    // An ALU redirect outranks anything in D: the D instruction is wrong-path.
    assign do_issue    = d_valid && !b_is_hazard;
    assign decode_jump = do_issue && (d_ope == OPE_J || d_ope == OPE_JAL);

    // Same-cycle writeback is forwarded so dependent neighbours never stall.
    always_comb begin
        ds_fwd = rf[d_ds];
        dt_fwd = rf[d_dt];
        if (d_ds != 6'd0 && d_ds == reg_addr) ds_fwd = reg_dd_val;
        if (d_dt != 6'd0 && d_dt == reg_addr) dt_fwd = reg_dd_val;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            f_pc    <= RESET_PC;
            d_pc    <= RESET_PC;
            d_valid <= 1'b0;
        end else begin
            d_pc <= f_pc;
            if (b_is_hazard) begin
                f_pc    <= b_addr;
                d_valid <= 1'b0;
            end else if (decode_jump) begin
                f_pc    <= d_target;
                d_valid <= 1'b0;
            end else begin
                f_pc    <= f_pc + 14'd1;
                d_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 64; i++) rf[i] <= 32'd0;
        end else if (reg_addr != 6'd0) begin
            rf[reg_addr] <= reg_dd_val;
        end
    end

    // issue_valid qualifies the issue registers for exactly one cycle; the ALU
    // takes every cycle, so there is no ready and bubbles carry BUBBLE_OPE.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ope         <= BUBBLE_OPE;
            pc          <= 14'd0;
            ds_val      <= 32'd0;
            dt_val      <= 32'd0;
            dd          <= 6'd0;
            imm         <= 16'd0;
            opr         <= 5'd0;
            issue_valid <= 1'b0;
        end else if (do_issue) begin
            ope         <= d_ope;
            pc          <= d_pc;
            ds_val      <= ds_fwd;
            dt_val      <= dt_fwd;
            dd          <= d_dd;
            imm         <= d_imm;
            opr         <= d_opr;
            issue_valid <= 1'b1;
        end else begin
            ope         <= BUBBLE_OPE;
            ds_val      <= 32'd0;
            dt_val      <= 32'd0;
            dd          <= 6'd0;
            imm         <= 16'd0;
            opr         <= 5'd0;
            issue_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: instruction memory and a combinational ALU around the
// DUT, a hand-derived issue table, and an ISA-level reference for random code.
module tb_decode_issue;
    localparam logic [5:0] BUBBLE_OPE = 6'b000010;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BLE  = 6'b000101;
    localparam logic [5:0] OP_JAL  = 6'b000110;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_UNK  = 6'b111111;
    localparam int EW = 8 + 14 + 6 + 6 + 16 + 5 + 32 + 32;

    typedef struct {
        int          bub;
        logic [13:0] pc;
        logic [5:0]  ope;
        logic [5:0]  dd;
        logic [31:0] ds_val;
        logic [31:0] dt_val;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [13:0] imem_addr;
    logic [31:0] imem_data;
    logic        b_is_hazard;
    logic [13:0] b_addr;
    logic [5:0]  reg_addr;
    logic [31:0] reg_dd_val;
    logic [5:0]  ope;
    logic [13:0] pc;
    logic [31:0] ds_val;
    logic [31:0] dt_val;
    logic [5:0]  dd;
    logic [15:0] imm;
    logic [4:0]  opr;
    logic        issue_valid;

    logic [31:0]   mem [0:16383];
    logic [EW-1:0] exp_q[$];
    logic [13:0]   last_pc;
    int            errors = 0;
    int            checks = 0;
    vec_t          vt [15];

    decode_issue #(.RESET_PC(14'd0), .BUBBLE_OPE(BUBBLE_OPE)) dut (
        .clk(clk), .rstn(rstn), .imem_addr(imem_addr), .imem_data(imem_data),
        .b_is_hazard(b_is_hazard), .b_addr(b_addr), .reg_addr(reg_addr),
        .reg_dd_val(reg_dd_val), .ope(ope), .pc(pc), .ds_val(ds_val),
        .dt_val(dt_val), .dd(dd), .imm(imm), .opr(opr), .issue_valid(issue_valid)
    );

    // ---- clock / memory / ALU environment
    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= mem[imem_addr];

    always_comb begin
        b_is_hazard = 1'b0;
        b_addr      = 14'd0;
        reg_addr    = 6'd0;
        reg_dd_val  = 32'd0;
        case (ope)
            OP_R: begin
                reg_addr   = dd;
                reg_dd_val = (opr == 5'd1) ? ds_val - dt_val : ds_val + dt_val;
            end
            OP_ADDI: begin
                reg_addr   = dd;
                reg_dd_val = ds_val + {{18{imm[13]}}, imm[13:0]};
            end
            OP_BEQ: begin
                b_is_hazard = (ds_val == dt_val);
                b_addr      = imm[13:0];
            end
            OP_BLE: begin
                b_is_hazard = ($signed(ds_val) <= $signed(dt_val));
                b_addr      = imm[13:0];
            end
            OP_JAL: begin
                reg_addr   = 6'd31;
                reg_dd_val = {18'd0, pc + 14'd1};
            end
            default: ;
        endcase
    end

    // ---- encoders and checker
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [5:0] d,
                                          input logic [5:0] s, input logic [13:0] i14);
        return {op, d, s, i14};
    endfunction

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [5:0] d,
                                          input logic [5:0] s, input logic [5:0] t,
                                          input logic [4:0] o);
        return {op, d, s, t, 3'b000, o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---- driver tasks
    task automatic reset_check(input string tag);
        check({tag, "_issue_valid"}, {31'd0, issue_valid}, 32'd0);
        check({tag, "_ope"}, {26'd0, ope}, {26'd0, BUBBLE_OPE});
        check({tag, "_pc"}, {18'd0, pc}, 32'd0);
        check({tag, "_operands_zero"}, {31'd0, (ds_val == 0 && dt_val == 0)}, 32'd1);
        check({tag, "_fields_zero"}, {31'd0, (dd == 0 && imm == 0 && opr == 0)}, 32'd1);
        check({tag, "_imem_addr"}, {18'd0, imem_addr}, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rstn = 1'b0;
        @(negedge clk);
        reset_check(tag);
        rstn    = 1'b1;
        last_pc = 14'd0;
    endtask

    task automatic wait_issue(output int bub, output bit ok);
        bub = 0;
        ok  = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (issue_valid === 1'b1) begin
                ok      = 1'b1;
                last_pc = pc;
                return;
            end
            bub++;
            check("bubble_outputs", {31'd0, (ope == BUBBLE_OPE && dd == 0 && imm == 0 &&
                  opr == 0 && ds_val == 0 && dt_val == 0 && pc == last_pc)}, 32'd1);
        end
        checks++;
        errors++;
        $display("FAIL issue_timeout: got no issue in 8 cycles, expected an issue");
    endtask

    // ---- ISA-level reference: architectural state plus bubble cost of each redirect
    task automatic ref_build(input int n);
        logic [31:0] arch [0:63];
        logic [13:0] rpc;
        logic [31:0] w, a, b, res;
        logic [5:0]  op, d, s, t;
        logic [7:0]  bub;
        bit          taken;
        for (int i = 0; i < 64; i++) arch[i] = 32'd0;
        rpc = 14'd0;
        bub = 8'd1;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            w  = mem[rpc];
            op = w[31:26]; d = w[25:20]; s = w[19:14]; t = w[13:8];
            a  = arch[s];
            b  = arch[t];
            exp_q.push_back({bub, rpc, op, d, w[15:0], w[4:0], a, b});
            bub = 8'd0;
            case (op)
                OP_R, OP_ADDI: begin
                    if (op == OP_ADDI) res = a + {{18{w[13]}}, w[13:0]};
                    else res = (w[4:0] == 5'd1) ? a - b : a + b;
                    if (d != 6'd0) arch[d] = res;
                    rpc = rpc + 14'd1;
                end
                OP_BEQ, OP_BLE: begin
                    taken = (op == OP_BEQ) ? (a == b) : ($signed(a) <= $signed(b));
                    if (taken) begin
                        rpc = w[13:0];
                        bub = 8'd2;
                    end else begin
                        rpc = rpc + 14'd1;
                    end
                end
                OP_J, OP_JAL: begin
                    if (op == OP_JAL) arch[31] = {18'd0, rpc + 14'd1};
                    rpc = w[13:0];
                    bub = 8'd1;
                end
                default: rpc = rpc + 14'd1;
            endcase
        end
    endtask

    task automatic run_ref(input string tag, input int n);
        logic [EW-1:0] e;
        logic [7:0]  eb;
        logic [13:0] epc;
        logic [5:0]  eope, edd;
        logic [15:0] eimm;
        logic [4:0]  eopr;
        logic [31:0] eds, edt;
        int bub;
        bit ok;
        for (int k = 0; k < n; k++) begin
            wait_issue(bub, ok);
            if (!ok) return;
            e = exp_q.pop_front();
            {eb, epc, eope, edd, eimm, eopr, eds, edt} = e;
            check({tag, "_bubbles"}, bub, {24'd0, eb});
            check({tag, "_pc"}, {18'd0, pc}, {18'd0, epc});
            check({tag, "_ope"}, {26'd0, ope}, {26'd0, eope});
            check({tag, "_dd"}, {26'd0, dd}, {26'd0, edd});
            check({tag, "_imm"}, {16'd0, imm}, {16'd0, eimm});
            check({tag, "_opr"}, {27'd0, opr}, {27'd0, eopr});
            check({tag, "_ds_val"}, ds_val, eds);
            check({tag, "_dt_val"}, dt_val, edt);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        int r, d, s, t, tg;
        r  = $urandom_range(0, 99);
        d  = $urandom_range(0, 7);
        s  = $urandom_range(0, 7);
        t  = $urandom_range(0, 7);
        tg = $urandom_range(0, 63);
        if ($urandom_range(0, 7) == 0) s = 31;
        if (r < 40) return enc_i(OP_ADDI, d[5:0], s[5:0], 14'($urandom_range(0, 16383)));
        if (r < 65) return enc_r(OP_R, d[5:0], s[5:0], t[5:0], 5'($urandom_range(0, 1)));
        if (r < 73) return enc_i(OP_BEQ, 6'd0, s[5:0], tg[13:0]);
        if (r < 81) return enc_i(OP_BLE, 6'd0, s[5:0], tg[13:0]);
        if (r < 87) return enc_i(OP_J, 6'd0, 6'd0, tg[13:0]);
        if (r < 93) return enc_i(OP_JAL, 6'd0, 6'd0, tg[13:0]);
        return {OP_UNK, d[5:0], s[5:0], t[5:0], 8'($urandom)};
    endfunction

    // ---- test sequence
    initial begin
        int  bub;
        bit  ok;
        bit  seen;
        for (int a = 0; a < 16384; a++) mem[a] = 32'd0;
        mem[0]  = enc_i(OP_ADDI, 6'd1, 6'd0, 14'd5);
        mem[1]  = enc_i(OP_ADDI, 6'd2, 6'd1, 14'd3);
        mem[2]  = enc_r(OP_R, 6'd3, 6'd1, 6'd2, 5'd0);
        mem[3]  = enc_r(OP_R, 6'd4, 6'd3, 6'd1, 5'd1);
        mem[4]  = enc_i(OP_BEQ, 6'd0, 6'd0, 14'd20);
        mem[5]  = enc_i(OP_ADDI, 6'd6, 6'd0, 14'd1);
        mem[6]  = enc_i(OP_ADDI, 6'd6, 6'd0, 14'd2);
        mem[20] = enc_i(OP_J, 6'd0, 6'd0, 14'd40);
        mem[21] = enc_i(OP_ADDI, 6'd7, 6'd0, 14'd9);
        mem[40] = enc_i(OP_JAL, 6'd0, 6'd0, 14'd60);
        mem[41] = enc_i(OP_ADDI, 6'd7, 6'd0, 14'd9);
        mem[60] = enc_r(OP_R, 6'd5, 6'd31, 6'd0, 5'd0);
        mem[61] = enc_i(OP_BLE, 6'd0, 6'd0, 14'd80);
        mem[62] = enc_i(OP_J, 6'd0, 6'd0, 14'd100);
        mem[80] = enc_i(OP_ADDI, 6'd0, 6'd0, 14'd7);
        mem[81] = enc_r(OP_R, 6'd5, 6'd0, 6'd0, 5'd0);
        mem[82] = enc_r(OP_R, 6'd8, 6'd4, 6'd2, 5'd1);
        mem[83] = {OP_UNK, 6'd9, 6'd1, 6'd2, 8'h5A};
        mem[84] = enc_i(OP_J, 6'd0, 6'd0, 14'd84);

        vt[0]  = '{1, 14'd0,  OP_ADDI, 6'd1, 32'd0,  32'd0};
        vt[1]  = '{0, 14'd1,  OP_ADDI, 6'd2, 32'd5,  32'd0};
        vt[2]  = '{0, 14'd2,  OP_R,    6'd3, 32'd5,  32'd8};
        vt[3]  = '{0, 14'd3,  OP_R,    6'd4, 32'd13, 32'd5};
        vt[4]  = '{0, 14'd4,  OP_BEQ,  6'd0, 32'd0,  32'd0};
        vt[5]  = '{2, 14'd20, OP_J,    6'd0, 32'd0,  32'd0};
        vt[6]  = '{1, 14'd40, OP_JAL,  6'd0, 32'd0,  32'd0};
        vt[7]  = '{1, 14'd60, OP_R,    6'd5, 32'd41, 32'd0};
        vt[8]  = '{0, 14'd61, OP_BLE,  6'd0, 32'd0,  32'd0};
        vt[9]  = '{2, 14'd80, OP_ADDI, 6'd0, 32'd0,  32'd0};
        vt[10] = '{0, 14'd81, OP_R,    6'd5, 32'd0,  32'd0};
        vt[11] = '{0, 14'd82, OP_R,    6'd8, 32'd8,  32'd8};
        vt[12] = '{0, 14'd83, OP_UNK,  6'd9, 32'd5,  32'd8};
        vt[13] = '{0, 14'd84, OP_J,    6'd0, 32'd0,  32'd0};
        vt[14] = '{1, 14'd84, OP_J,    6'd0, 32'd0,  32'd0};

        do_reset("reset0");
        for (int i = 0; i < 15; i++) begin
            wait_issue(bub, ok);
            if (!ok) break;
            check($sformatf("vec%0d_bubbles", i), bub, vt[i].bub);
            check($sformatf("vec%0d_pc", i), {18'd0, pc}, {18'd0, vt[i].pc});
            check($sformatf("vec%0d_ope", i), {26'd0, ope}, {26'd0, vt[i].ope});
            check($sformatf("vec%0d_dd", i), {26'd0, dd}, {26'd0, vt[i].dd});
            check($sformatf("vec%0d_ds_val", i), ds_val, vt[i].ds_val);
            check($sformatf("vec%0d_dt_val", i), dt_val, vt[i].dt_val);
        end

        // Reset for one cycle while a taken branch is redirecting.
        do_reset("reset1");
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (issue_valid === 1'b1 && ope == OP_BEQ) seen = 1'b1;
        end
        check("midreset_branch_seen", {31'd0, seen}, 32'd1);
        mem[0] = enc_r(OP_R, 6'd9, 6'd3, 6'd4, 5'd0);
        mem[1] = enc_r(OP_R, 6'd10, 6'd1, 6'd2, 5'd1);
        do_reset("midreset");
        ref_build(2);
        run_ref("midreset_probe", 2);

        // PC wrap from 14'h3FFF back to 0.
        mem[0]     = enc_i(OP_J, 6'd0, 6'd0, 14'h3FFE);
        mem[16382] = enc_i(OP_ADDI, 6'd1, 6'd0, 14'd1);
        mem[16383] = enc_r(OP_R, 6'd2, 6'd1, 6'd1, 5'd0);
        do_reset("reset_wrap");
        ref_build(7);
        run_ref("wrap", 7);

        for (int p = 0; p < 3; p++) begin
            for (int a = 0; a < 64; a++) mem[a] = rand_instr();
            mem[64] = enc_i(OP_J, 6'd0, 6'd0, 14'd0);
            do_reset($sformatf("reset_rand%0d", p));
            ref_build(300);
            run_ref($sformatf("rand%0d", p), 300);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running at 2000000, expected finish");
        $fatal(1, "global timeout");
    end
endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
- Front end of the core3rd pipeline: fetch PC generation, instruction decode, 64-entry register file read/write, and issue into the single-cycle ALU stage.
- Drives the ALU's operand/opcode inputs.
- Consumes the ALU's registered outputs:
  - b_is_hazard/b_addr for redirect and flush;
  - reg_addr/reg_dd_val for writeback and bypass.
- Resolves J/JAL itself. Branches, JR and JALR are resolved by the ALU.

Parameters:
- RESET_PC, 14'd0, first fetch address after reset
- BUBBLE_OPE, 6'b000010, opcode issued as a bubble (J: ALU clears b_is_hazard and reg_addr)

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- imem_addr  out  14  instruction memory address (= f_pc, combinational)
- imem_data  in  32  instruction word for the previous cycle's imem_addr (1-cycle synchronous read)
- b_is_hazard  in  1  ALU redirect request (taken branch / JR / JALR)
- b_addr  in  14  ALU redirect target
- reg_addr  in  6  ALU writeback register (0 = no write)
- reg_dd_val  in  32  ALU writeback value
- ope  out  6  issued opcode
- pc  out  14  PC of issued instruction
- ds_val  out  32  source s operand
- dt_val  out  32  source t operand
- dd  out  6  destination register
- imm  out  16  immediate
- opr  out  5  sub-operation field
- issue_valid  out  1  1 = real instruction issued this cycle, 0 = bubble

Behaviour:
- Reset: rstn is synchronous, active-low; clock is clk.
  - Register values: f_pc=RESET_PC, d_valid=0, ope=BUBBLE_OPE.
  - Outputs: pc, ds_val, dt_val, dd, imm, opr and issue_valid all 0.
  - Register file cleared to 0.
  - Reset mid-operation discards all in-flight instructions.
- Pipeline: F (imem_addr=f_pc) -> D (imem_data arrives, d_pc=previous f_pc) -> issue registers (ALU inputs) -> ALU.
- Sequencing: in steady state f_pc increments by 1 per cycle. There is no stall source.
- Field decode of instruction word w:
  - ope=w[31:26], dd=w[25:20], ds=w[19:14], dt=w[13:8];
  - imm=w[15:0], opr=w[4:0];
  - jump target=w[13:0].
  - Every ope is passed through unchanged, including codes the ALU does not yet implement.
- Register file:
  - 64x32.
  - Write at posedge when reg_addr!=0: rf[reg_addr]<=reg_dd_val.
  - Register 0 reads 0 and is never written.
- Operand bypass:
  - ds_val = (ds!=0 && ds==reg_addr) ? reg_dd_val : rf[ds]. dt_val is formed the same way.
  - Back-to-back dependent instructions therefore issue with no stall.
- Issue at posedge when d_valid=1 and no flush:
  - outputs <= decoded fields and operands;
  - pc <= d_pc;
  - issue_valid <= 1.
- Bubble (d_valid=0 or flush):
  - ope<=BUBBLE_OPE, dd<=0, imm<=0, opr<=0, ds_val<=0, dt_val<=0;
  - issue_valid<=0, pc unchanged.
- Decode jump (d_valid=1, ope J 000010 or JAL 000110, b_is_hazard=0):
  - The instruction is issued normally (JAL's r31=pc+1 write is done by the ALU).
  - f_pc<=target and d_valid<=0, killing the sequential fetch in flight.
  - Cost: 1 bubble.
- ALU redirect (b_is_hazard=1):
  - f_pc<=b_addr.
  - The instruction currently in D is flushed (bubble issued).
  - d_valid<=0.
  - Cost: 2 bubbles.
  - Takes priority over a decode jump in the same cycle; that jump is wrong-path and is ignored.
  - Because the flush bubble is BUBBLE_OPE, b_is_hazard drops the following cycle and no double redirect occurs.
- d_valid:
  - set to 1 on every cycle without a redirect;
  - first valid D occurs in cycle 2 after reset release.
- PC arithmetic is 14-bit and wraps: 14'h3FFF+1 = 0.
- Simultaneous writeback and read of the same register: the bypass supplies the new value. Register 0 is never bypassed.

Test Plan:
- Reset, straight-line code (mem[0..3] = ADDI r1,r0,5; ADDI r2,r1,3; ADD r3,r1,r2; SUB r4,r3,r1) -> issue_valid first high with pc=0; ALU results r1=5, r2=8, r3=13, r4=8, all via bypass with no bubbles.
- BEQ r0,r0,imm=14'd20 at pc=4 -> exactly two issue_valid=0 cycles; next issued pc=20; pc 5 and 6 never issued.
- J target 10 at pc=2 -> J issued with pc=2; one bubble; next issued pc=10. JAL at pc=3 to 40 -> ALU writes r31=4; next issued pc=40.
- Redirect and decode jump together (BLE taken to 30 while a J to 50 sits in D) -> next issued pc=30; the J is never issued.
- Write to r0 (ADDI r0,r0,7) followed by ADD r5,r0,r0 -> ds_val=dt_val=0 and r5=0. f_pc wrap from 14'h3FFF gives next fetch at 0.
- rstn pulled low for one cycle mid-stream after a taken branch -> all outputs return to reset values; registers read 0; fetch restarts at RESET_PC.
